display_scan_driver: RTL and testbench
======================================

Name: display_scan_driver

Overview:
- Time-multiplexes NDIGITS display characters onto one shared seven-segment decoder.
- Sits directly upstream of the 4-bit-code-to-segment decoder: drives its BCD nibble and dp inputs, and drives the common-anode digit enables (active-low) of the board display.
- Holds a double-buffered character frame so the controlling logic can update it at any time without tearing; new content takes effect only at frame boundaries.
- A blanking gap between digit slots suppresses ghosting.

Parameters:
- NDIGITS, 8, number of multiplexed digits (2..16).
- SCAN_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 16, cycles at the start of each slot during which all anodes are off.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- load  in  1  one-cycle strobe; captures digits_in/dp_in into the pending buffer.
- digits_in  in  4*NDIGITS  character codes; digit i = bits [4i+3:4i]; digit 0 is rightmost.
- dp_in  in  NDIGITS  per-digit decimal-point bit, passed through unchanged to dp.
- BCD  out  4  code for the decoder, for the currently scanned digit.
- dp  out  1  dp bit for the currently scanned digit.
- AN  out  NDIGITS  anode enables, active-low, at most one bit low.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- load_ack  out  1  one-cycle pulse when pending data is committed to the display buffer.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high (rst). All outputs are registered.

Reset values:
- AN = all 1.
- BCD = 4'ha (dash).
- dp = 1.
- frame_tick = 0 and load_ack = 0.
- Display and pending buffers: every digit = 4'ha; every dp bit = 1.
- Pending-valid flag = 0.
- slot counter cnt = 0; digit index idx = 0.

Counters:
- cnt runs 0..SCAN_DIV-1 and wraps.
- On a cnt wrap, idx advances; idx runs 0..NDIGITS-1 and wraps to 0.
- Frame = NDIGITS*SCAN_DIV cycles.

Per-slot states (derived from cnt):
- BLANK: cnt < BLANK_CYCLES. AN = all 1.
- SHOW: cnt >= BLANK_CYCLES. AN[idx] = 0, all other AN bits = 1.
- BCD and dp are updated to the display-buffer entry for idx during the first BLANK cycle, so they are stable before SHOW begins.
- BCD/dp never change while any AN bit is low.

Output timing:
- Outputs reflect the counter state one cycle late (registered).
- First edge after rst deasserts: cnt = 0, idx = 0.
- AN[0] first goes low at edge BLANK_CYCLES+1 after reset release.

Frame boundary (idx = NDIGITS-1 and cnt = SCAN_DIV-1):
- frame_tick pulses for exactly one cycle.
- If pending-valid = 1: the pending buffer copies into the display buffer, load_ack pulses in the same cycle, and pending-valid clears.
- If pending-valid = 0: load_ack stays 0 and the display buffer is unchanged.

Load handshake:
- load = 1 captures both inputs into the pending buffer and sets pending-valid.
- A second load before commit overwrites the pending buffer (last wins); only one load_ack is issued.
- A load in the boundary cycle itself is not committed in that cycle; it is committed at the next boundary.
- A load at any other time is committed at the next boundary.

Reset mid-operation:
- rst = 1 in any cycle forces all reset values on the next edge.
- Pending data is discarded and no load_ack is issued.

Character codes are not interpreted here; all 16 codes pass straight through to BCD.

Test Plan (NDIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, frame = 32 cycles):
1. Reset, then free-run 64 cycles -> AN = 4'b1111 for 2 cycles of each slot, then 4'b1110, 4'b1101, 4'b1011, 4'b0111 for 6 cycles each; BCD = 4'ha throughout; frame_tick pulses every 32 cycles.
2. load with digits_in = 16'h4321, dp_in = 4'b1110 mid-frame -> no display change until the boundary; load_ack and frame_tick pulse together; next frame BCD = 1,2,3,4 with dp = 0,1,1,1 on digits 0..3.
3. Two loads in one frame (16'h1111 then 16'hbcde) -> single load_ack; next frame shows e,d,c,b on digits 0..3.
4. load asserted exactly in the boundary cycle -> no load_ack at that boundary; load_ack and the new data appear at the following boundary, 32 cycles later.
5. Throughout every run -> never more than one AN bit low; BCD never changes in a cycle where AN != all 1.
6. Assert rst during the SHOW phase of digit 2 with a pending load -> next cycle AN = 4'b1111, BCD = 4'ha; scan restarts at digit 0; no load_ack; pending data lost.

Source files
------------

// File: rtl/display_scan_driver.sv
// Multiplexed seven-segment scan driver: walks NDIGITS characters through one shared decoder,
// with a blanking gap per slot and a double-buffered frame that swaps only at frame boundaries.
module display_scan_driver #(
  parameter int NDIGITS      = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   digits_in,
  input  logic [NDIGITS-1:0]     dp_in,
  output logic [3:0]             BCD,
  output logic                   dp,
  output logic [NDIGITS-1:0]     AN,
  output logic                   frame_tick,
  output logic                   load_ack
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NDIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIGITS - 1);
  localparam logic [4*NDIGITS-1:0] DASHES = {NDIGITS{4'ha}};

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*NDIGITS-1:0] disp_code_q, disp_code_d;
  logic [NDIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NDIGITS-1:0] pend_code_q, pend_code_d;
  logic [NDIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [3:0]           bcd_q, bcd_d;
  logic                 dp_q, dp_d;
  logic [NDIGITS-1:0]   an_q, an_d;
  logic                 frame_tick_q, frame_tick_d;
  logic                 load_ack_q, load_ack_d;

  logic slot_end, boundary, commit, show, slot_start;

  always_comb begin
    slot_end   = (cnt_q == CNT_LAST);
    boundary   = slot_end && (idx_q == IDX_LAST);
    commit     = boundary && pend_valid_q;
    show       = (cnt_q >= BLANK_END);
    slot_start = (cnt_q == '0);
  end

  // Slot and digit counters
  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A load in the boundary cycle lands in the pending buffer after the commit has used the old contents
  always_comb begin
    pend_code_d  = load ? digits_in : pend_code_q;
    pend_dp_d    = load ? dp_in     : pend_dp_q;
    pend_valid_d = load ? 1'b1 : (commit ? 1'b0 : pend_valid_q);
    disp_code_d  = commit ? pend_code_q : disp_code_q;
    disp_dp_d    = commit ? pend_dp_q   : disp_dp_q;
  end

  // Code and dp latch only on the first blanking cycle, so they are settled before any anode turns on
  always_comb begin
    bcd_d        = bcd_q;
    dp_d         = dp_q;
    if (slot_start) begin
      bcd_d = disp_code_q[4*int'(idx_q) +: 4];
      dp_d  = disp_dp_q[idx_q];
    end
    frame_tick_d = boundary;
    load_ack_d   = commit;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_anode
      assign an_d[gi] = !(show && (idx_q == IDX_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_code_q  <= DASHES;
      disp_dp_q    <= '1;
      pend_code_q  <= DASHES;
      pend_dp_q    <= '1;
      pend_valid_q <= 1'b0;
      bcd_q        <= 4'ha;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_code_q  <= disp_code_d;
      disp_dp_q    <= disp_dp_d;
      pend_code_q  <= pend_code_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      bcd_q        <= bcd_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign BCD        = bcd_q;
  assign dp         = dp_q;
  assign AN         = an_q;
  assign frame_tick = frame_tick_q;
  assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized bench for display_scan_driver; the reference model derives every output from
// elapsed cycles since reset plus a frame-level model of the pending/display buffers.
module tb_display_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   digits_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    BCD;
  logic          dp;
  logic [3:0]    AN;
  logic          frame_tick;
  logic          load_ack;

  display_scan_driver #(.NDIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .BCD(BCD), .dp(dp), .AN(AN), .frame_tick(frame_tick), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int          t = 0;
  logic [3:0]  m_disp[ND];
  logic        m_disp_dp[ND];
  logic [3:0]  m_pend[ND];
  logic        m_pend_dp[ND];
  logic        m_pv = 1'b0;
  logic [3:0]  e_an = 4'hf, e_bcd = 4'ha;
  logic        e_dp = 1'b1, e_ft = 1'b0, e_la = 1'b0;
  logic [3:0]  prev_bcd = 4'ha;
  int          n_acks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // Advance the model on the edge the DUT just took, using the inputs sampled at that edge
  task automatic model_edge();
    int s, slot, pos, dig;
    if (rst) begin
      e_an = 4'hf; e_bcd = 4'ha; e_dp = 1'b1; e_ft = 1'b0; e_la = 1'b0;
      for (int i = 0; i < ND; i++) begin
        m_disp[i] = 4'ha; m_disp_dp[i] = 1'b1; m_pend[i] = 4'ha; m_pend_dp[i] = 1'b1;
      end
      m_pv = 1'b0;
      t = 0;
    end else begin
      s    = t;
      pos  = s % SD;
      slot = s / SD;
      dig  = slot % ND;
      e_an  = (pos < BC) ? 4'hf : ~(4'b0001 << dig);
      e_bcd = m_disp[dig];
      e_dp  = m_disp_dp[dig];
      e_ft  = ((s % FRAME) == FRAME - 1);
      e_la  = e_ft && m_pv;
      if (e_la) begin
        for (int i = 0; i < ND; i++) begin
          m_disp[i] = m_pend[i]; m_disp_dp[i] = m_pend_dp[i];
        end
        m_pv = 1'b0;
      end
      if (load) begin
        for (int i = 0; i < ND; i++) begin
          m_pend[i] = digits_in[4*i +: 4]; m_pend_dp[i] = dp_in[i];
        end
        m_pv = 1'b1;
      end
      t++;
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] d, input logic [3:0] p);
    int low;
    rst = r; load = l; digits_in = d; dp_in = p;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("AN", 32'(AN), 32'(e_an));
    chk("BCD", 32'(BCD), 32'(e_bcd));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
    chk("load_ack", 32'(load_ack), 32'(e_la));
    low = 0;
    for (int i = 0; i < ND; i++) if (!AN[i]) low++;
    chk("an_onehot", 32'(low <= 1), 32'd1);
    if (BCD !== prev_bcd) chk("bcd_stable_blank", 32'(AN), 32'hf);
    prev_bcd = BCD;
    if (load_ack) n_acks++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != phase; i++) idle(1);
  endtask

  int acks_before;

  initial begin
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    // free run with reset contents
    idle(64);
    // mid-frame load
    run_to(10);
    step(1'b0, 1'b1, 16'h4321, 4'b1110);
    idle(FRAME + 10);
    // two loads in one frame, only the last should appear
    acks_before = n_acks;
    run_to(3);
    step(1'b0, 1'b1, 16'h1111, 4'b0000);
    idle(5);
    step(1'b0, 1'b1, 16'hbcde, 4'b0101);
    run_to(0);
    chk("single_ack", 32'(n_acks - acks_before), 32'd1);
    idle(FRAME);
    // load sampled exactly on the boundary edge
    run_to(FRAME - 1);
    acks_before = n_acks;
    step(1'b0, 1'b1, 16'h9876, 4'b0011);
    chk("no_ack_at_load_boundary", 32'(n_acks - acks_before), 32'd0);
    idle(FRAME + 4);
    chk("ack_next_boundary", 32'(n_acks - acks_before), 32'd1);
    // reset during SHOW of digit 2 with a pending load
    run_to(2 * SD + 4);
    step(1'b0, 1'b1, 16'h5555, 4'b0000);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    acks_before = n_acks;
    idle(2 * FRAME);
    chk("no_ack_after_reset", 32'(n_acks - acks_before), 32'd0);
    // randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
           16'($urandom), 4'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
